// File: rtl/inst_issue_queue_if.sv
// Issue queue port bundle: fetch-side push slots, two-wide head view, issue
// handshake and occupancy.
//   master : fetch/decode side (drives pushes and issue_a/issue_b)
//   slave  : the queue (drives push_ready, out_*, occupancy)
interface inst_issue_queue_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

   logic [1:0]       push_valid;
   logic [31:0]      push_pc0;
   logic [31:0]      push_pc1;
   logic [31:0]      push_inst0;
   logic [31:0]      push_inst1;
   logic             push_ready;

   logic             out_valid_a;
   logic             out_valid_b;
   logic [31:0]      out_pc_a;
   logic [31:0]      out_inst_a;
   logic [31:0]      out_pc_b;
   logic [31:0]      out_inst_b;
   logic             issue_a;
   logic             issue_b;

   logic [OCC_W-1:0] occupancy;

   modport master (
      output push_valid, push_pc0, push_pc1, push_inst0, push_inst1,
      output issue_a, issue_b,
      input  push_ready, out_valid_a, out_valid_b,
      input  out_pc_a, out_inst_a, out_pc_b, out_inst_b, occupancy
   );

   modport slave (
      input  push_valid, push_pc0, push_pc1, push_inst0, push_inst1,
      input  issue_a, issue_b,
      output push_ready, out_valid_a, out_valid_b,
      output out_pc_a, out_inst_a, out_pc_b, out_inst_b, occupancy
   );
endinterface

// File: rtl/inst_issue_queue.sv
// Dual-push / dual-pop in-order instruction issue queue between fetch and ID.
// Circular buffer with read pointer, write pointer and entry count. The head
// and head+1 entries are presented on out_*_a / out_*_b straight from storage
// (no push bypass).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop all entries (mispredict / exception)
//   stall           : ID stalled, suppresses pops
//   q (slave)       : push slots, head view, issue handshake, occupancy
//   perf_*_cnt      : dual-issue / single-issue / empty cycle counters
// Optional feature: define INST_QUEUE_PERF_EN to build the perf counters;
// otherwise the perf ports are tied to zero.
module inst_issue_queue #(
   parameter int unsigned DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               stall,
   inst_issue_queue_if.slave  q,
   output logic [31:0]        perf_dual_cnt,
   output logic [31:0]        perf_single_cnt,
   output logic [31:0]        perf_empty_cnt
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic [31:0] mem_pc   [DEPTH];
   logic [31:0] mem_inst [DEPTH];

   logic       ready_c;
   logic       valid_a_c;
   logic       valid_b_c;
   logic [1:0] push_cnt_c;
   logic [1:0] pop_cnt_c;

   // Status derived from the registered count only
   assign ready_c   = (count <= CNT_W'(DEPTH - 2));
   assign valid_a_c = (count != '0);
   assign valid_b_c = (count >= CNT_W'(2));

   // Accepted pushes / pops this cycle; slot1 alone is not a valid push
   always_comb begin
      push_cnt_c = 2'd0;
      pop_cnt_c  = 2'd0;
      if (ready_c && q.push_valid[0]) begin
         push_cnt_c = q.push_valid[1] ? 2'd2 : 2'd1;
      end
      if (!stall && !flush && q.issue_a && valid_a_c) begin
         pop_cnt_c = (q.issue_b && valid_b_c) ? 2'd2 : 2'd1;
      end
   end

   // Pointer and count state; flush and reset discard same-cycle traffic
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(pop_cnt_c);
         wr_ptr <= wr_ptr + PTR_W'(push_cnt_c);
         count  <= count + CNT_W'(push_cnt_c) - CNT_W'(pop_cnt_c);
      end
   end

   // Entry storage, not reset; slot1 lands one entry after slot0
   always_ff @(posedge clk) begin
      if (!rst && !flush && push_cnt_c != 2'd0) begin
         mem_pc[wr_ptr]   <= q.push_pc0;
         mem_inst[wr_ptr] <= q.push_inst0;
         if (push_cnt_c == 2'd2) begin
            mem_pc[wr_ptr + PTR_W'(1)]   <= q.push_pc1;
            mem_inst[wr_ptr + PTR_W'(1)] <= q.push_inst1;
         end
      end
   end

   assign q.push_ready  = ready_c;
   assign q.out_valid_a = valid_a_c;
   assign q.out_valid_b = valid_b_c;
   assign q.out_pc_a    = mem_pc[rd_ptr];
   assign q.out_inst_a  = mem_inst[rd_ptr];
   assign q.out_pc_b    = mem_pc[rd_ptr + PTR_W'(1)];
   assign q.out_inst_b  = mem_inst[rd_ptr + PTR_W'(1)];
   assign q.occupancy   = count;

`ifdef INST_QUEUE_PERF_EN
   // Issue-bandwidth counters; stall, flush and reset cycles are not counted
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_dual_cnt   <= '0;
         perf_single_cnt <= '0;
         perf_empty_cnt  <= '0;
      end else if (!stall && !flush) begin
         if (pop_cnt_c == 2'd2) perf_dual_cnt   <= perf_dual_cnt + 32'd1;
         if (pop_cnt_c == 2'd1) perf_single_cnt <= perf_single_cnt + 32'd1;
         if (!valid_a_c)        perf_empty_cnt  <= perf_empty_cnt + 32'd1;
      end
   end
`else
   assign perf_dual_cnt   = '0;
   assign perf_single_cnt = '0;
   assign perf_empty_cnt  = '0;
`endif

endmodule

// File: doc/inst_issue_queue.md
INST_ISSUE_QUEUE -- requirements
Module: inst_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, minimum 4.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discard all entries (branch mispredict / exception).
REQ-005 stall  input  1  ID stage stalled; pops suppressed.
REQ-006 push_valid  input  2  fetch slots valid; bit1 is legal only with bit0.
REQ-007 push_pc0, push_pc1  input  32 each  PCs of slot0, slot1; slot0 is older.
REQ-008 push_inst0, push_inst1  input  32 each  instruction words.
REQ-009 push_ready  output  1  at least 2 free entries.
REQ-010 out_valid_a, out_valid_b  output  1 each  head / head+1 entry present.
REQ-011 out_pc_a, out_inst_a, out_pc_b, out_inst_b  output  32 each  head and head+1 contents.
REQ-012 issue_a  input  1  pipe A consumed the head entry.
REQ-013 issue_b  input  1  pipe B also consumed head+1; driven from dual-issue decision.
REQ-014 occupancy  output  log2(DEPTH)+1  entry count.

Function
REQ-015 Circular buffer with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-016 Push count = push_valid[0] + (push_valid[0] & push_valid[1]), accepted only when push_ready=1; slot0 written at write pointer, slot1 at write pointer+1.
REQ-017 push_valid with push_ready=0 is dropped with no state change.
REQ-018 push_valid=2'b10 is treated as no push.
REQ-019 Pop count = 0 if stall or flush; otherwise issue_a&out_valid_a plus issue_a&issue_b&out_valid_b.
REQ-020 issue_b without issue_a pops nothing; issue_b with out_valid_b=0 pops only the head.
REQ-021 push_ready = (DEPTH - count) >= 2, from registered count only; pops in the same cycle do not raise it.
REQ-022 Simultaneous push and pop: count_next = count + pushes - pops; both pointers advance in the same edge.
REQ-023 Outputs come from registered state; a pushed entry appears on out_* the cycle after the push edge, with no bypass.
REQ-024 out_valid_a = count>=1; out_valid_b = count>=2; out_pc/out_inst of an invalid slot are don't-care.
REQ-025 Flush: read pointer, write pointer and count go to 0 on the next edge; same-cycle pushes and pops are discarded.
REQ-026 Flush has priority over stall, push and pop.
REQ-027 Entries keep program order; out_*_a is always older than out_*_b.

Reset
REQ-028 Synchronous rst clears both pointers and count; out_valid_a=0, out_valid_b=0, push_ready=1, occupancy=0.
REQ-029 Data storage is not reset.
REQ-030 rst mid-operation behaves as flush plus perf counter clear, and overrides all inputs.

Configuration
REQ-031 Macro INST_QUEUE_PERF_EN adds 32-bit outputs perf_dual_cnt, perf_single_cnt and perf_empty_cnt.
REQ-032 With INST_QUEUE_PERF_EN, counters increment per cycle, excluding stall, flush and rst cycles:
- perf_dual_cnt: pop count = 2
- perf_single_cnt: pop count = 1
- perf_empty_cnt: out_valid_a=0
REQ-033 With INST_QUEUE_PERF_EN, perf counters wrap at 2^32 and clear on rst only.
REQ-034 Without INST_QUEUE_PERF_EN, the ports exist, are tied to 0, and no counter flops are built.

Verification
REQ-035 Reset, then push 2'b11 (pc 0x100, 0x104): next cycle out_valid_a=1, out_valid_b=1, out_pc_a=0x100, out_pc_b=0x104, occupancy=2.
REQ-036 Queue holds 0x100..0x10C (count 4); issue_a=1, issue_b=1 with no push: next cycle out_pc_a=0x108, out_pc_b=0x10C, occupancy=2; with PERF_EN, perf_dual_cnt=1.
REQ-037 Fill to DEPTH-1=7 entries: push_ready=0; push of 2'b11 dropped, occupancy stays 7; issue_a only: next cycle occupancy=6, push_ready=1.
REQ-038 Wrap-around: 20 cycles of push 2 / pop 2 starting at count 2: PCs leave in strict +4 order, occupancy stays 2.
REQ-039 Flush asserted with push 2'b11 and issue_a=1: next cycle occupancy=0, out_valid_a=0, and no pushed PC ever appears.
REQ-040 Stall=1 with issue_a=1, issue_b=1 and count 3: occupancy stays 3, head unchanged; with PERF_EN, no counter changes.
